ram_port_arbiter: RTL and testbench

- Shares the 256x32 dual-read/single-write RAM among NUM_CLIENTS requesters.
- Each cycle it grants one write (RAM write port) and up to two reads (RAM read ports A and B), using independent round-robin pointers for writes and reads.
- It returns read data to the issuing client with fixed latency.
- Sits directly between client blocks and the RAM instance.

---
 rtl/ram_arb_pkg.sv | 28 ++
 rtl/ram_port_arbiter_rr_pick.sv | 31 +++
 rtl/ram_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared parameters, tag layout and index helpers for the RAM port arbiter.
package ram_arb_pkg;

    localparam int NUM_CLIENTS_DEF = 4;
    localparam int ADDR_W_DEF      = 8;
    localparam int DATA_W_DEF      = 32;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W = idx_w(NUM_CLIENTS_DEF);

    // Port tag = {valid, client index}; the index field covers the 8-client maximum.
    localparam int TAG_IDX_W   = 3;
    localparam int TAG_W       = TAG_IDX_W + 1;
    localparam int TAG_VLD_BIT = TAG_IDX_W;
    localparam logic [TAG_W-1:0] TAG_IDLE = {TAG_W{1'b0}};

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

    function automatic logic [TAG_W-1:0] make_tag(input logic vld, input int idx);
        return {vld, TAG_IDX_W'(idx)};
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the start index.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Walk the requests from start with wrap-around; the first hit wins.
    always_comb begin
        logic [IW-1:0] c;
        logic          hit;
        grant = {N{1'b0}};
        idx   = {IW{1'b0}};
        any   = 1'b0;
        c     = {IW{1'b0}};
        hit   = 1'b0;
        for (int k = 0; k < N; k++) begin
            c        = IW'((int'(start) + k) % N);
            hit      = req[c] & ~any;
            grant[c] = hit;
            idx      = hit ? c : idx;
            any      = any | hit;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one write port and two synchronous read ports of a RAM among several clients,
// returning read data to the issuing client one cycle after its grant.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = NUM_CLIENTS_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CLIENTS-1:0]        req_valid,
    input  logic [NUM_CLIENTS-1:0]        req_write,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] req_wdata,
    output logic [NUM_CLIENTS-1:0]        req_ready,
    output logic [NUM_CLIENTS-1:0]        rsp_valid,
    output logic [NUM_CLIENTS*DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0]             ram_addr_a,
    output logic [ADDR_W-1:0]             ram_addr_b,
    output logic [ADDR_W-1:0]             ram_addr_wr,
    output logic [DATA_W-1:0]             ram_data_in,
    output logic                          ram_we,
    input  logic [DATA_W-1:0]             ram_data_a,
    input  logic [DATA_W-1:0]             ram_data_b
);

    localparam int IW = idx_w(NUM_CLIENTS);

    logic [IW-1:0]          wr_ptr_r;
    logic [IW-1:0]          rd_ptr_r;
    logic [TAG_W-1:0]       tag_a_r;
    logic [TAG_W-1:0]       tag_b_r;

    logic [NUM_CLIENTS-1:0] wr_req_s;
    logic [NUM_CLIENTS-1:0] rd_elig_s;
    logic [NUM_CLIENTS-1:0] rd_req_b_s;
    logic [NUM_CLIENTS-1:0] wr_gnt_s;
    logic [NUM_CLIENTS-1:0] a_gnt_s;
    logic [NUM_CLIENTS-1:0] b_gnt_s;
    logic [IW-1:0]          wr_idx_s;
    logic [IW-1:0]          a_idx_s;
    logic [IW-1:0]          b_idx_s;
    logic [IW-1:0]          b_start_s;
    logic                   wr_any_s;
    logic                   a_any_s;
    logic                   b_any_s;
    logic [ADDR_W-1:0]      wr_addr_s;

    // Write candidates.
    always_comb begin
        wr_req_s = req_valid & req_write;
    end

    rr_pick #(.N(NUM_CLIENTS), .IW(IW)) u_wr_pick (
        .req(wr_req_s), .start(wr_ptr_r), .grant(wr_gnt_s), .idx(wr_idx_s), .any(wr_any_s)
    );

    // Readers hitting the address being written this cycle wait, so they see the new data.
    always_comb begin
        wr_addr_s = req_addr[wr_idx_s*ADDR_W +: ADDR_W];
        rd_elig_s = {NUM_CLIENTS{1'b0}};
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            rd_elig_s[i] = req_valid[i] && !req_write[i] &&
                           !(wr_any_s && (req_addr[i*ADDR_W +: ADDR_W] == wr_addr_s));
        end
    end

    rr_pick #(.N(NUM_CLIENTS), .IW(IW)) u_rd_a_pick (
        .req(rd_elig_s), .start(rd_ptr_r), .grant(a_gnt_s), .idx(a_idx_s), .any(a_any_s)
    );

    // Port B searches after port A's winner, with that winner removed.
    always_comb begin
        b_start_s  = IW'(wrap_inc(int'(a_idx_s), NUM_CLIENTS));
        rd_req_b_s = rd_elig_s & ~a_gnt_s;
    end

    rr_pick #(.N(NUM_CLIENTS), .IW(IW)) u_rd_b_pick (
        .req(rd_req_b_s), .start(b_start_s), .grant(b_gnt_s), .idx(b_idx_s), .any(b_any_s)
    );

    // Grant handshake and RAM port drive; everything forced low while in reset.
    always_comb begin
        req_ready   = {NUM_CLIENTS{1'b0}};
        ram_we      = 1'b0;
        ram_addr_wr = {ADDR_W{1'b0}};
        ram_data_in = {DATA_W{1'b0}};
        ram_addr_a  = {ADDR_W{1'b0}};
        ram_addr_b  = {ADDR_W{1'b0}};
        if (rst_n) begin
            req_ready   = wr_gnt_s | a_gnt_s | b_gnt_s;
            ram_we      = wr_any_s;
            ram_addr_wr = wr_any_s ? wr_addr_s : {ADDR_W{1'b0}};
            ram_data_in = wr_any_s ? req_wdata[wr_idx_s*DATA_W +: DATA_W] : {DATA_W{1'b0}};
            ram_addr_a  = a_any_s ? req_addr[a_idx_s*ADDR_W +: ADDR_W] : {ADDR_W{1'b0}};
            ram_addr_b  = b_any_s ? req_addr[b_idx_s*ADDR_W +: ADDR_W] : {ADDR_W{1'b0}};
        end else begin
            req_ready = {NUM_CLIENTS{1'b0}};
        end
    end

    // Round-robin pointers and per-port response tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {IW{1'b0}};
            rd_ptr_r <= {IW{1'b0}};
            tag_a_r  <= TAG_IDLE;
            tag_b_r  <= TAG_IDLE;
        end else begin
            wr_ptr_r <= wr_any_s ? IW'(wrap_inc(int'(wr_idx_s), NUM_CLIENTS)) : wr_ptr_r;
            if (b_any_s) begin
                rd_ptr_r <= IW'(wrap_inc(int'(b_idx_s), NUM_CLIENTS));
            end else if (a_any_s) begin
                rd_ptr_r <= IW'(wrap_inc(int'(a_idx_s), NUM_CLIENTS));
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            tag_a_r <= make_tag(a_any_s, int'(a_idx_s));
            tag_b_r <= make_tag(b_any_s, int'(b_idx_s));
        end
    end

    // Route the RAM read data to the client named in each valid tag.
    always_comb begin
        rsp_valid = {NUM_CLIENTS{1'b0}};
        rsp_rdata = {(NUM_CLIENTS*DATA_W){1'b0}};
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (tag_a_r[TAG_VLD_BIT] && (tag_a_r[TAG_IDX_W-1:0] == TAG_IDX_W'(i))) begin
                rsp_valid[i]                 = 1'b1;
                rsp_rdata[i*DATA_W +: DATA_W] = ram_data_a;
            end else if (tag_b_r[TAG_VLD_BIT] && (tag_b_r[TAG_IDX_W-1:0] == TAG_IDX_W'(i))) begin
                rsp_valid[i]                 = 1'b1;
                rsp_rdata[i*DATA_W +: DATA_W] = ram_data_b;
            end else begin
                rsp_valid[i]                 = 1'b0;
                rsp_rdata[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed scenarios followed by random traffic,
// with a behavioural RAM and a reference model of the arbitration rules.
module tb_ram_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata, rsp_rdata;
    logic [AW-1:0]   ram_addr_a, ram_addr_b, ram_addr_wr;
    logic [DW-1:0]   ram_data_in, ram_data_a, ram_data_b;
    logic            ram_we;

    ram_port_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b), .ram_addr_wr(ram_addr_wr),
        .ram_data_in(ram_data_in), .ram_we(ram_we), .ram_data_a(ram_data_a), .ram_data_b(ram_data_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           client;
        int           due;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            wp, rp, mode, fair_cnt;
    logic          p_valid[N];
    logic          p_write[N];
    logic [AW-1:0] p_addr[N];
    logic [DW-1:0] p_wdata[N];
    logic [N-1:0]  acc;
    logic [DW-1:0] ref_mem[256];
    logic [DW-1:0] ram[256];
    logic [DW-1:0] last_rsp[N];
    logic          ram_fill;

    function automatic logic [DW-1:0] init_val(input int a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = p_valid[i];
            req_write[i]           = p_write[i];
            req_addr[i*AW +: AW]   = p_addr[i];
            req_wdata[i*DW +: DW]  = p_wdata[i];
        end
    end

    // Behavioural 256x32 RAM: one write port, two synchronous read ports.
    always @(posedge clk) begin
        if (ram_fill) begin
            for (int a = 0; a < 256; a++) ram[a] <= init_val(a);
        end else if (ram_we) begin
            ram[ram_addr_wr] <= ram_data_in;
        end
        ram_data_a <= ram[ram_addr_a];
        ram_data_b <= ram[ram_addr_b];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops every response due this cycle and compares the whole response bus.
    always @(negedge clk) begin
        logic [N-1:0]    ev;
        logic [N*DW-1:0] ed;
        ev = '0;
        ed = '0;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            ev[e.client]        = 1'b1;
            ed[e.client*DW +: DW] = e.data;
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(ev));
        for (int i = 0; i < N; i++) begin
            chk("rsp_rdata", 64'(rsp_rdata[i*DW +: DW]), 64'(ed[i*DW +: DW]));
            if (rsp_valid[i]) last_rsp[i] = rsp_rdata[i*DW +: DW];
        end
    end

    // Reference arbitration for the coming edge, applied from the specification's rules.
    task automatic model_step();
        logic [N-1:0]  er;
        int            w, ra, rb;
        logic [AW-1:0] ea, eb, ewa;
        logic [DW-1:0] ewd;
        exp_t          e;
        er = '0; w = -1; ra = -1; rb = -1;
        ea = '0; eb = '0; ewa = '0; ewd = '0;
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (wp + k) % N;
                if (w < 0 && p_valid[c] && p_write[c]) w = c;
            end
            for (int k = 0; k < N; k++) begin
                int c;
                c = (rp + k) % N;
                if (p_valid[c] && !p_write[c] && !(w >= 0 && p_addr[c] == p_addr[w])) begin
                    if (ra < 0) ra = c;
                    else if (rb < 0) rb = c;
                end
            end
        end
        if (w >= 0) begin er[w] = 1'b1; ewa = p_addr[w]; ewd = p_wdata[w]; end
        if (ra >= 0) begin er[ra] = 1'b1; ea = p_addr[ra]; end
        if (rb >= 0) begin er[rb] = 1'b1; eb = p_addr[rb]; end
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("ram_we", 64'(ram_we), 64'(w >= 0));
        chk("ram_addr_wr", 64'(ram_addr_wr), 64'(ewa));
        chk("ram_data_in", 64'(ram_data_in), 64'(ewd));
        chk("ram_addr_a", 64'(ram_addr_a), 64'(ea));
        chk("ram_addr_b", 64'(ram_addr_b), 64'(eb));
        acc = er;
        if (ra >= 0) begin e.client = ra; e.due = cyc + 1; e.data = ref_mem[p_addr[ra]]; sb.push_back(e); end
        if (rb >= 0) begin e.client = rb; e.due = cyc + 1; e.data = ref_mem[p_addr[rb]]; sb.push_back(e); end
        if (w >= 0) begin ref_mem[p_addr[w]] = p_wdata[w]; wp = (w + 1) % N; end
        if (rb >= 0) rp = (rb + 1) % N;
        else if (ra >= 0) rp = (ra + 1) % N;
    endtask

    task automatic set_req(input int i, input logic wr, input int a, input logic [DW-1:0] d);
        p_valid[i] = 1'b1; p_write[i] = wr; p_addr[i] = AW'(a); p_wdata[i] = d;
    endtask

    task automatic new_rand(input int i);
        set_req(i, $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom);
    endtask

    task automatic step(input bit do_chk, input string nm, input logic [N-1:0] exp_rdy);
        @(negedge clk);
        if (do_chk) chk(nm, 64'(req_ready), 64'(exp_rdy));
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                if (mode == 2) begin
                    set_req(i, 1'b1, 32 + fair_cnt, $urandom);
                    fair_cnt++;
                end else begin
                    p_valid[i] = 1'b0;
                end
            end
            if (mode == 1 && !p_valid[i] && $urandom_range(0, 2) != 0) new_rand(i);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] pend;
        mode = 0; fair_cnt = 0; wp = 0; rp = 0; acc = '0;
        for (int i = 0; i < N; i++) begin
            p_valid[i] = 1'b0; p_write[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0; last_rsp[i] = '0;
        end
        for (int a = 0; a < 256; a++) ref_mem[a] = init_val(a);
        ram_fill = 1'b1;
        rst_n = 1'b0;
        set_req(0, 1'b1, 9, 32'h1234_5678);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 64'(req_ready), 64'h0);
        chk("reset_we", 64'(ram_we), 64'h0);
        chk("reset_addr_wr", 64'(ram_addr_wr), 64'h0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
        p_valid[0] = 1'b0;
        ram_fill = 1'b0;
        rst_n = 1'b1;

        // Dual read from rd_ptr=0: clients 0 and 1 first, client 2 next cycle.
        set_req(0, 1'b0, 1, '0); set_req(1, 1'b0, 2, '0); set_req(2, 1'b0, 3, '0);
        step(1, "dual_rd_first", 4'b0011);
        step(1, "dual_rd_second", 4'b0100);
        step(1, "dual_rd_idle", 4'b0000);
        chk("dual_rsp0", 64'(last_rsp[0]), 64'(init_val(1)));
        chk("dual_rsp1", 64'(last_rsp[1]), 64'(init_val(2)));
        chk("dual_rsp2", 64'(last_rsp[2]), 64'(init_val(3)));

        // Write then readback.
        set_req(0, 1'b1, 1, 32'hA5A5_A5A5);
        step(1, "wb_write", 4'b0001);
        set_req(1, 1'b0, 1, '0);
        step(1, "wb_read", 4'b0010);
        step(0, "", '0);
        step(0, "", '0);
        chk("wb_rsp1", 64'(last_rsp[1]), 64'hA5A5_A5A5);

        // Read colliding with a same-cycle write is deferred and sees the new data.
        set_req(2, 1'b1, 0, 32'hDEAD_BEEF);
        set_req(3, 1'b0, 0, '0);
        step(1, "hz_write", 4'b0100);
        step(1, "hz_read", 4'b1000);
        step(0, "", '0);
        step(0, "", '0);
        chk("hz_rsp3", 64'(last_rsp[3]), 64'hDEAD_BEEF);

        // Reset just after a read grant: response suppressed, outputs clear at once.
        set_req(1, 1'b0, 5, '0);
        step(1, "rst_rd_grant", 4'b0010);
        set_req(2, 1'b1, 6, 32'h0BAD_F00D);
        rst_n = 1'b0;
        sb.delete(); wp = 0; rp = 0;
        #1;
        chk("rst_async_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_async_rsp_rdata", 64'(rsp_rdata[DW*2-1:0]), 64'h0);
        chk("rst_async_ready", 64'(req_ready), 64'h0);
        chk("rst_async_we", 64'(ram_we), 64'h0);
        @(posedge clk);
        #1;
        p_valid[2] = 1'b0;
        rst_n = 1'b1;

        // Continuous writers from all clients rotate starting at client 0.
        mode = 2;
        for (int i = 0; i < N; i++) begin
            set_req(i, 1'b1, 32 + fair_cnt, $urandom);
            fair_cnt++;
        end
        step(1, "fair_0", 4'b0001);
        step(1, "fair_1", 4'b0010);
        step(1, "fair_2", 4'b0100);
        step(1, "fair_3", 4'b1000);
        step(1, "fair_4", 4'b0001);

        // Random mixed traffic on a small address range to provoke hazards and dual reads.
        mode = 1;
        for (int n = 0; n < 400; n++) step(0, "", '0);

        mode = 0;
        for (int n = 0; n < 50; n++) begin
            pend = '0;
            for (int i = 0; i < N; i++) pend[i] = p_valid[i];
            if (pend != '0) step(0, "", '0);
        end
        for (int i = 0; i < N; i++) pend[i] = p_valid[i];
        chk("drain_pending", 64'(pend), 64'h0);
        step(0, "", '0);
        step(0, "", '0);
        chk("sb_empty", 64'(sb.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
